control_unit: RTL
=================

Name: control_unit

Overview:
- Multi-cycle Moore sequencer directly upstream of the CPU datapath.
- Drives every register-enable, bus-select, memory, ALU-op and IR-field-select control that the datapath consumes.
- Sequences fetch (T0–T2) and per-opcode execute steps (T3–T7).
- Takes the IR word and the CON flip-flop bit back from the datapath.

Parameters:
- MEM_LAT, 1, cycles a memory read/write step is held (>=1)
- DATA_WIDTH, 32, IR width

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-low reset
- ir  in  32  IR contents from datapath; opcode=ir[31:27]
- con_ff_bit  in  1  branch condition from CON flip-flop
- stop  in  1  request halt at next instruction boundary
- IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in  out  1 each  register load enables
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  out  1 each  bus source selects
- Gra, Grb, Grc, Rin, Rout, BAout, CONin  out  1 each  IR-field register select/strobes
- Mem_read  out  1  RAM read / MDR source select
- Mem_write  out  1  RAM write strobe
- IncPC  out  1  ALU increments bus value (PC+1)
- opcode  out  5  ALU operation
- run  out  1  1 while executing, 0 in reset/HALT

Behaviour:
- Moore outputs decoded from state only. Every control is 0 unless listed for a step.
- clear==0 at a clock edge: state<=RST and the wait counter clears. In RST all outputs are 0 and run=0. Next state is T0.
- Reset overrides everything, including mid-instruction and HALT. No partial enables leak in the cycle after reset.
- T0: PCout, MARin, IncPC, RZin.
- T1: Zlo_out, PCin (first cycle only); Mem_read held MEM_LAT cycles; MDRin only in the last cycle.
- T2: MDRout, IRin.
- T3 decodes from ir[31:27].
- opcode output:
  - ir[31:27] during ALU-compute steps.
  - ADD (00011) during address/branch-target computation.
  - 0 otherwise.
- ld: T3 Grb, BAout, RYin; T4 Cout, RZin (ADD); T5 Zlo_out, MARin; T6 read step (as T1, without PCin); T7 MDRout, Gra, Rin.
- ldi: T3, T4 as ld; T5 Zlo_out, Gra, Rin.
- st: T3–T5 as ld; T6 Gra, Rout, MDRin (Mem_read=0); T7 Mem_write held MEM_LAT cycles.
- add/sub/and/or/ror/rol/shr/shra/shl: T3 Grb, Rout, RYin; T4 Grc, Rout, RZin; T5 Zlo_out, Gra, Rin.
- addi/andi/ori: as R-type, but T4 uses Cout instead of Grc/Rout.
- neg/not: T3 Grb, Rout, RZin; T4 Zlo_out, Gra, Rin.
- mul/div: T3 Gra, Rout, RYin; T4 Grb, Rout, RZin; T5 Zlo_out, LOin; T6 Zhi_out, HIin.
- br: T3 Gra, Rout, CONin; T4 PCout, RYin; T5 Cout, RZin (ADD); T6 Zlo_out, PCin only if con_ff_bit==1, else empty step.
- jr: T3 Gra, Rout, PCin.
- jal: T3 PCout, Grb, Rin; T4 Gra, Rout, PCin.
- in: T3 Inport_out, Gra, Rin.
- out: T3 Gra, Rout, Outport_in.
- mfhi/mflo: T3 HIout/LOout, Gra, Rin.
- nop and undefined opcodes 11100–11111: T3 empty, then T0.
- halt: enter HALT; all outputs 0, run=0; leave only via reset.
- After an instruction's last step: next state T0, or HALT if stop==1 sampled in that cycle. stop never aborts an instruction in progress.
- Wait counter: clog2(MEM_LAT+1) bits. Loads on entry to a memory step, decrements each cycle, step advances at 1. With MEM_LAT=1 every step is one cycle.
- PCin in T1 is asserted only in its first cycle, so PC increments once.

Decomposition:
- Package cpu_ctrl_pkg:
  - 5-bit opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
  - State encoding: RST, T0–T7, HALT.
- No sub-module; the wait counter stays inline.

Test Plan:
- clear=0 for 2 cycles: all outputs 0, run=0. Release: the 2nd cycle shows PCout=MARin=IncPC=RZin=1, run=1.
- ir=0x18918000 (add R1,R2,R3), MEM_LAT=1: T3 Grb+Rout+RYin; T4 Grc+Rout+RZin, opcode=00011; T5 Zlo_out+Gra+Rin; T0 follows. Instruction totals 6 cycles.
- MEM_LAT=3, ld: Mem_read high 3 consecutive cycles in T1 and T6; MDRin only on the 3rd; PCin exactly once.
- br: con_ff_bit=0 gives no PCin in T6; con_ff_bit=1 gives Zlo_out+PCin in T6.
- ir=0xD8000000 (halt): run=0, all outputs 0 for 20 cycles. stop=1 raised during T4 of an add: T5 completes, then HALT.
- clear=0 during T4 of mul: next cycle all outputs 0, HIin/LOin never asserted. After release, fetch restarts at T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode constants, sequencer states and control-word layout for control_unit
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  // Field order matches the port concatenation in control_unit.
  typedef struct packed {
    logic       ir_in;
    logic       pc_in;
    logic       ry_in;
    logic       rz_in;
    logic       mar_in;
    logic       mdr_in;
    logic       hi_in;
    logic       lo_in;
    logic       outport_in;
    logic       hi_out;
    logic       lo_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       mdr_out;
    logic       inport_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       con_in;
    logic       mem_read;
    logic       mem_write;
    logic       inc_pc;
    logic [4:0] opcode;
    logic       run;
  } ctrl_t;

  // Final execute step of each opcode; nop, halt and undefined opcodes end at T3.
  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:              last_step = T7;
      OP_MUL, OP_DIV, OP_BR:     last_step = T6;
      OP_NEG, OP_NOT, OP_JAL:    last_step = T4;
      default:                   last_step = (op >= OP_LDI && op <= OP_ORI) ? T5 : T3;
    endcase
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer driving all datapath controls (fetch T0-T2, execute T3-T7)
// Ports: clock/clear (sync active-low reset), ir + con_ff_bit from datapath, stop halts at the
// next instruction boundary; outputs are register enables, bus selects, IR-field strobes,
// memory strobes, IncPC, ALU opcode and run.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  con_ff_bit,
  input  logic                  stop,
  output logic                  IRin,
  output logic                  PCin,
  output logic                  RYin,
  output logic                  RZin,
  output logic                  MARin,
  output logic                  MDRin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  Outport_in,
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Zhi_out,
  output logic                  Zlo_out,
  output logic                  PCout,
  output logic                  MDRout,
  output logic                  Inport_out,
  output logic                  Cout,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic                  CONin,
  output logic                  Mem_read,
  output logic                  Mem_write,
  output logic                  IncPC,
  output logic [4:0]            opcode,
  output logic                  run
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0] op;
  logic mem_step, adv, first, last, s3, s4, s5, s6, s7;
  logic ir_unused;
  ctrl_t c;
  assign op = ir[DATA_WIDTH-1 -: 5];
  assign ir_unused = ^ir[DATA_WIDTH-6:0];
  assign first = cnt == CW'(MEM_LAT);
  assign last = cnt == CW'(1);
  assign s3 = state == T3;
  assign s4 = state == T4;
  assign s5 = state == T5;
  assign s6 = state == T6;
  assign s7 = state == T7;
  assign mem_step = state == T1 || (s6 && op == OP_LD) || (s7 && op == OP_ST);
  // Counter sits at MEM_LAT whenever a step is entered; memory steps count it down to 1.
  assign adv = !mem_step || last;
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= RST;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    cnt_nxt = adv ? CW'(MEM_LAT) : cnt - CW'(1);
    state_nxt = state;
    if (state == RST)
      state_nxt = T0;
    else if (state != HALT && adv)
      state_nxt = (s3 && op == OP_HALT) ? HALT
                : (state == last_step(op)) ? (stop ? HALT : T0)
                : state_t'(state + 4'd1);
  end
  always_comb begin
    c = '0;
    c.run = state != RST && state != HALT;
    case (state)
      T0: begin
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.inc_pc = 1'b1;
        c.rz_in = 1'b1;
      end
      T1: begin
        c.zlo_out = 1'b1;
        c.pc_in = first;
        c.mem_read = 1'b1;
        c.mdr_in = last;
      end
      T2: begin
        c.mdr_out = 1'b1;
        c.ir_in = 1'b1;
      end
      T3, T4, T5, T6, T7: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            c.grb = s3;
            c.ba_out = s3;
            c.ry_in = s3;
            c.c_out = s4;
            c.rz_in = s4;
            c.opcode = s4 ? OP_ADD : 5'd0;
            c.zlo_out = s5;
            c.mar_in = s5 && op != OP_LDI;
            c.gra = (s5 && op == OP_LDI) || (s6 && op == OP_ST) || (s7 && op == OP_LD);
            c.r_in = (s5 && op == OP_LDI) || (s7 && op == OP_LD);
            c.r_out = s6 && op == OP_ST;
            c.mdr_in = s6 && (op == OP_ST || last);
            c.mem_read = s6 && op == OP_LD;
            c.mdr_out = s7 && op == OP_LD;
            c.mem_write = s7 && op == OP_ST;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            c.grb = s3;
            c.ry_in = s3;
            c.grc = s4 && op < OP_ADDI;
            c.c_out = s4 && op >= OP_ADDI;
            c.r_out = s3 || (s4 && op < OP_ADDI);
            c.rz_in = s4;
            c.opcode = s4 ? op : 5'd0;
            c.zlo_out = s5;
            c.gra = s5;
            c.r_in = s5;
          end
          OP_NEG, OP_NOT: begin
            c.grb = s3;
            c.r_out = s3;
            c.rz_in = s3;
            c.opcode = s3 ? op : 5'd0;
            c.zlo_out = s4;
            c.gra = s4;
            c.r_in = s4;
          end
          OP_MUL, OP_DIV: begin
            c.gra = s3;
            c.ry_in = s3;
            c.grb = s4;
            c.rz_in = s4;
            c.r_out = s3 || s4;
            c.opcode = s4 ? op : 5'd0;
            c.zlo_out = s5;
            c.lo_in = s5;
            c.zhi_out = s6;
            c.hi_in = s6;
          end
          OP_BR: begin
            c.gra = s3;
            c.r_out = s3;
            c.con_in = s3;
            c.pc_out = s4;
            c.ry_in = s4;
            c.c_out = s5;
            c.rz_in = s5;
            c.opcode = s5 ? OP_ADD : 5'd0;
            c.zlo_out = s6 && con_ff_bit;
            c.pc_in = s6 && con_ff_bit;
          end
          OP_JR: begin
            c.gra = s3;
            c.r_out = s3;
            c.pc_in = s3;
          end
          OP_JAL: begin
            c.pc_out = s3;
            c.grb = s3;
            c.r_in = s3;
            c.gra = s4;
            c.r_out = s4;
            c.pc_in = s4;
          end
          OP_IN: begin
            c.inport_out = s3;
            c.gra = s3;
            c.r_in = s3;
          end
          OP_OUT: begin
            c.gra = s3;
            c.r_out = s3;
            c.outport_in = s3;
          end
          OP_MFHI, OP_MFLO: begin
            c.hi_out = s3 && op == OP_MFHI;
            c.lo_out = s3 && op == OP_MFLO;
            c.gra = s3;
            c.r_in = s3;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
  assign {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, HIout, LOout, Zhi_out,
          Zlo_out, PCout, MDRout, Inport_out, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CONin,
          Mem_read, Mem_write, IncPC, opcode, run} = c;
endmodule
